// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front-end.
// PC values are word indices; one instruction per PC step.
package fetch_pkg;

    localparam int PC_WIDTH    = 64;
    localparam int INSTR_WIDTH = 32;
    localparam int PC_STEP     = 1;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a single-cycle clear; the head is read from
// registered storage, so a pushed entry is visible one cycle after the push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: issues sequential PCs to an in-order memory,
// queues {pc, instr} pairs, and flushes/drops stale responses on redirect.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   mem_req_valid,
    output logic [PC_WIDTH-1:0]    mem_req_addr,
    input  logic                   mem_req_ready,
    input  logic                   mem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] mem_rsp_data,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [PC_WIDTH-1:0]    instr_pc,
    input  logic                   instr_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                req_valid_q, req_valid_d;
    logic                req_fire, rsp_live, push, pop;
    fetch_entry_t        push_entry, head_entry;
    logic [ENTRY_WIDTH-1:0] head_bits;

    assign req_fire    = req_valid_q && mem_req_ready;
    // A response with nothing owed is a protocol error and is ignored.
    assign rsp_live    = mem_rsp_valid && ((outstanding_q != '0) || (drop_q != '0));
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        push          = 1'b0;

        if (req_fire) fetch_pc_d = fetch_pc_q + PC_WIDTH'(PC_STEP);

        if (redirect_valid) begin
            // Everything still owed by memory becomes stale; a response
            // arriving this very cycle is one of them and is dropped now.
            fetch_pc_d    = redirect_pc;
            rsp_pc_d      = redirect_pc;
            drop_d        = drop_q + outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
            outstanding_d = '0;
        end else if (state_q == FETCH) begin
            push          = rsp_live;
            outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
            if (rsp_live) rsp_pc_d = rsp_pc_q + PC_WIDTH'(PC_STEP);
        end else if (rsp_live) begin
            drop_d = drop_q - CNT_W'(1);
        end

        state_d = (drop_d != '0) ? FLUSH : FETCH;
        count_d = redirect_valid ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);

        // Precomputed from next state so the request strobe is a plain flop.
        req_valid_d = (state_d == FETCH) &&
                      ((SUM_W'(outstanding_d) + SUM_W'(count_d)) < SUM_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            fetch_pc_q    <= '0;
            rsp_pc_q      <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            req_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            req_valid_q   <= req_valid_d;
        end
    end

    assign push_entry = '{pc: rsp_pc_q, instr: mem_rsp_data};

    sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .clear_i (redirect_valid),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_bits),
        .count_o (count_q)
    );

    assign head_entry    = fetch_entry_t'(head_bits);
    assign instr_data    = instr_valid ? head_entry.instr : '0;
    assign instr_pc      = instr_valid ? head_entry.pc : '0;
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = fetch_pc_q;

    rsp_protocol_a: assert property (@(posedge clk) disable iff (reset)
        !(mem_rsp_valid && (outstanding_q == '0) && (drop_q == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order variable-latency memory model
// and a scoreboard of expected delivered PCs.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data  = '0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [63:0] instr_pc;
    logic        instr_ready;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] sb[$];
    logic [63:0] req_log[$];
    int          cyc = 0;
    int          lat = 1;
    int          checks = 0;
    int          failures = 0;
    int          pops = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ pc[63:32] ^ 32'hC0DE_F00D;
    endfunction

    // Memory model: responses come back in order, lat cycles after the request.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = instr_of(pend[0].addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            pend.delete();
        end else begin
            if (mem_rsp_valid) void'(pend.pop_front());
            if (mem_req_valid && mem_req_ready)
                pend.push_back('{addr: mem_req_addr, due: cyc + lat});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] log_at(input int i);
        return (i < req_log.size()) ? req_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    // One clock: observe handshakes at the falling edge, then return 2ns after the rising edge.
    task automatic step();
        logic [63:0] exp_pc;
        @(negedge clk);
        if (!reset) begin
            if (mem_req_valid && mem_req_ready) req_log.push_back(mem_req_addr);
            if (instr_valid && instr_ready) begin
                pops++;
                exp_pc = (sb.size() != 0) ? sb.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
                check("pop_pc", instr_pc, exp_pc);
                check("pop_data", {32'b0, instr_data}, {32'b0, instr_of(exp_pc)});
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        sb.delete();
        req_log.delete();
        pops  = 0;
        reset = 1'b0;
    endtask

    task automatic fill_sb(input logic [63:0] start, input int n);
        sb.delete();
        for (int i = 0; i < n; i++) sb.push_back(start + 64'(i));
    endtask

    initial begin
        int  t_req, p0, base;
        bit  found;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b1;
        instr_ready    = 1'b1;
        lat            = 1;

        // Reset values
        do_reset();
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_req_addr", mem_req_addr, 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_instr_data", {32'b0, instr_data}, 64'd0);
        check("rst_instr_pc", instr_pc, 64'd0);
        check("rst_state", 64'(dut.state_q), 64'(fetch_pkg::FETCH));

        // Streaming at latency 1
        fill_sb(64'd0, 40);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) if (mem_req_valid) found = 1; else step();
        check("first_req_seen", 64'(found), 64'd1);
        check("first_req_addr", mem_req_addr, 64'd0);
        t_req = cyc;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) if (instr_valid) found = 1; else step();
        check("first_instr_seen", 64'(found), 64'd1);
        check("first_instr_latency", 64'(cyc - t_req), 64'd2);
        check("first_instr_pc", instr_pc, 64'd0);
        repeat (10) step();
        for (int i = 0; i < 6; i++) check("stream_req_addr", log_at(i), 64'(i));
        check("stream_pops", 64'(pops >= 8), 64'd1);

        // Back-pressure: queue fills, requests stop at DEPTH
        instr_ready = 1'b0;
        do_reset();
        repeat (12) step();
        check("bp_req_count", 64'(req_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("bp_req_addr", log_at(i), 64'(i));
        check("bp_req_valid_low", 64'(mem_req_valid), 64'd0);
        check("bp_instr_valid", 64'(instr_valid), 64'd1);
        check("bp_head_pc", instr_pc, 64'd0);
        fill_sb(64'd0, 32);
        instr_ready = 1'b1;
        repeat (12) step();
        check("bp_resume_addr", log_at(4), 64'd4);
        check("bp_release_pops", 64'(pops >= 8), 64'd1);

        // Latency 3, redirect to 10 with two requests in flight
        lat           = 3;
        mem_req_ready = 1'b0;
        do_reset();
        repeat (3) step();
        base          = req_log.size();
        mem_req_ready = 1'b1;
        step();
        step();
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'd10;
        step();
        redirect_valid = 1'b0;
        check("flush_inflight", 64'(req_log.size() - base), 64'd2);
        check("flush_state", 64'(dut.state_q), 64'(fetch_pkg::FLUSH));
        check("flush_drop_cnt", 64'(dut.drop_q), 64'd2);
        check("flush_req_valid", 64'(mem_req_valid), 64'd0);
        fill_sb(64'd10, 40);
        base          = req_log.size();
        p0            = pops;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 30 && (pops - p0) < 3; i++) step();
        check("flush_next_addr", log_at(base), 64'd10);
        check("flush_pops", 64'(pops - p0 >= 3), 64'd1);
        check("flush_state_back", 64'(dut.state_q), 64'(fetch_pkg::FETCH));

        // Redirect to 20 together with a response and a pop
        found = 0;
        for (int i = 0; i < 40 && !found; i++)
            if (mem_rsp_valid && instr_valid) found = 1; else step();
        check("collide_found", 64'(found), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'd20;
        step();
        redirect_valid = 1'b0;
        check("collide_queue_empty", 64'(instr_valid), 64'd0);
        fill_sb(64'd20, 40);
        base = req_log.size();
        p0   = pops;
        for (int i = 0; i < 30 && (pops - p0) < 3; i++) step();
        check("collide_next_addr", log_at(base), 64'd20);
        check("collide_pops", 64'(pops - p0 >= 3), 64'd1);

        // Redirect near the top of the PC space
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        fill_sb(64'hFFFF_FFFF_FFFF_FFFE, 16);
        base = req_log.size();
        p0   = pops;
        for (int i = 0; i < 40 && (pops - p0) < 4; i++) step();
        check("wrap_addr0", log_at(base), 64'hFFFF_FFFF_FFFF_FFFE);
        check("wrap_addr2", log_at(base + 2), 64'd0);
        check("wrap_pops", 64'(pops - p0 >= 4), 64'd1);

        // Reset in the middle of a flush
        mem_req_ready = 1'b0;
        repeat (6) step();
        base          = req_log.size();
        mem_req_ready = 1'b1;
        step();
        step();
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'd40;
        step();
        redirect_valid = 1'b0;
        check("mid_inflight", 64'(req_log.size() - base), 64'd2);
        check("mid_flush_state", 64'(dut.state_q), 64'(fetch_pkg::FLUSH));
        check("mid_flush_drop", 64'(dut.drop_q), 64'd2);
        reset = 1'b1;
        step();
        check("mid_rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("mid_rst_req_addr", mem_req_addr, 64'd0);
        check("mid_rst_instr_valid", 64'(instr_valid), 64'd0);
        check("mid_rst_instr_data", {32'b0, instr_data}, 64'd0);
        check("mid_rst_instr_pc", instr_pc, 64'd0);
        check("mid_rst_state", 64'(dut.state_q), 64'(fetch_pkg::FETCH));
        check("mid_rst_drop", 64'(dut.drop_q), 64'd0);
        reset = 1'b0;
        fill_sb(64'd0, 16);
        base          = req_log.size();
        p0            = pops;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 30 && (pops - p0) < 3; i++) step();
        check("mid_rst_first_addr", log_at(base), 64'd0);
        check("mid_rst_pops", 64'(pops - p0 >= 3), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog timeout");
    end

endmodule
